// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// The parity feature is selected with the UART_TX_PARITY_EN macro, see uart_tx_buffered.sv.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Pushes are ignored when full and pops when empty.
// A simultaneous push and pop leaves the count unchanged.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = UART_DATA_BITS,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Storage array; not reset, since contents are only visible through the count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO plus 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
//
// state  | meaning
// IDLE   | line high, waiting for the FIFO to become non-empty
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// PARITY | even parity of the data byte (parity builds only)
// STOP   | stop bit (high); last cycle pops the next byte if present
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 10417,
  parameter  int FIFO_DEPTH   = 16,
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [UART_DATA_BITS-1:0] i_wr_data,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic [CNT_W-1:0]          o_fifo_count
);

  localparam int               BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            r_state;
  logic [BAUD_W-1:0]         r_baud;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_tx;

  logic                      w_baud_last;
  logic                      w_pop;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [UART_DATA_BITS-1:0] w_fifo_data;
  logic [CNT_W-1:0]          w_fifo_count;

  assign w_baud_last = (r_baud == BAUD_LAST);
  // Pop from IDLE, or on the last stop cycle so back-to-back frames have no gap.
  assign w_pop = !w_fifo_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_baud_last));

  uart_tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (UART_DATA_BITS)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (i_wr_valid),
    .i_push_data (i_wr_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  assign o_wr_ready   = !w_fifo_full;
  assign o_fifo_count = w_fifo_count;
  assign o_busy       = (r_state != IDLE) || (w_fifo_count != '0);
  assign o_tx         = r_tx;

  // Frame sequencer; the line level is registered from the current state, one cycle behind it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= UART_STOP_LVL;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= UART_STOP_LVL;
          r_baud <= '0;
          if (!w_fifo_empty) begin
            r_shift <= w_fifo_data;
            r_state <= START;
          end
        end
        START: begin
          r_tx <= UART_START_LVL;
          if (w_baud_last) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        DATA: begin
          r_tx <= r_shift[r_bit_idx];
          if (w_baud_last) begin
            r_baud    <= '0;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          r_tx <= ^r_shift;
          if (w_baud_last) begin
            r_baud  <= '0;
            r_state <= STOP;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          r_tx <= UART_STOP_LVL;
          if (w_baud_last) begin
            r_baud <= '0;
            if (!w_fifo_empty) begin
              r_shift <= w_fifo_data;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: begin
          r_tx    <= UART_STOP_LVL;
          r_baud  <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed phases plus random traffic, every cycle
// compared against a frame-level model (byte queue + expected line waveform).
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int C     = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_data    (wr_data),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_fifo_count (fifo_count)
  );

  int    n_chk  = 0;
  int    n_fail = 0;
  string phase  = "init";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s at %0t: got %0h expected %0h", phase, tag, $time, obs, exp);
    end
  endtask

  // Reference model: pending bytes, whether a frame is running, when it ends,
  // and the bit pattern of the frame currently on the line.
  byte unsigned m_q[$];
  int           m_cyc    = 0;
  bit           m_active = 1'b0;
  int           m_end    = 0;
  int           m_fstart = -100000;
  logic         m_bits [NBITS];
  logic         m_tx_exp = 1'b1;

  function automatic logic line_level(input int e);
    if (e >= m_fstart && e < m_fstart + FRAME) return m_bits[(e - m_fstart) / C];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d);
    bit           acc;
    bit           pop;
    byte unsigned b;
    m_cyc++;
    acc = v && (m_q.size() < DEPTH);
    pop = 1'b0;
    if (m_active) begin
      if (m_cyc == m_end) begin
        if (m_q.size() > 0) pop = 1'b1;
        else m_active = 1'b0;
      end
    end else if (m_q.size() > 0) begin
      pop = 1'b1;
    end
    m_tx_exp = line_level(m_cyc);
    if (pop) begin
      b        = m_q.pop_front();
      m_active = 1'b1;
      m_end    = m_cyc + FRAME;
      m_fstart = m_cyc + 1;
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      m_bits[9] = ^b;
`endif
      m_bits[NBITS-1] = 1'b1;
    end
    if (acc) m_q.push_back(d);
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    wr_valid = v;
    wr_data  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    chk("tx", tx, m_tx_exp);
    chk("busy", busy, m_active || (m_q.size() > 0));
    chk("wr_ready", wr_ready, m_q.size() < DEPTH);
    chk("fifo_count", fifo_count, m_q.size());
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_active || m_q.size() > 0) && guard < 4000) begin
      step(1'b0, 8'h00);
      guard++;
    end
    chk("drain_bound", guard < 4000, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    #2;
    rst      = 1'b1;
    wr_valid = 1'b0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", wr_ready, 1);
    m_q.delete();
    m_active = 1'b0;
    m_fstart = -100000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int target;
    int guard;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", wr_ready, 1);
    chk("reset_count", fifo_count, 0);
    rst = 1'b0;

    phase = "idle";
    for (int i = 0; i < 1000; i++) step(1'b0, 8'h00);

    phase = "single";
    step(1'b1, 8'h54);
    step(1'b0, 8'h00);
    chk("lat_e1", tx, 1);
    step(1'b0, 8'h00);
    chk("lat_e2", tx, 0);
    drain();
    chk("single_busy_end", busy, 0);
    step(1'b1, 8'h55);
    drain();

    phase = "back2back";
    step(1'b1, 8'h54);
    step(1'b1, 8'h68);
    step(1'b1, 8'h65);
    chk("b2b_count", fifo_count, 2);
    drain();

    phase = "full";
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i));
      if (i == 16) chk("full_ready_low", wr_ready, 0);
    end
    chk("full_held", fifo_count, 16);
    drain();

    phase = "rst_mid";
    step(1'b1, 8'h54);
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    target = m_fstart - 1 + 4 * C + 2;
    guard  = 0;
    while (m_cyc < target && guard < 200) begin
      step(1'b0, 8'h00);
      guard++;
    end
    chk("rst_mid_bound", guard < 200, 1);
    do_reset();
    step(1'b1, 8'h54);
    step(1'b0, 8'h00);
    chk("post_rst_e1", tx, 1);
    step(1'b0, 8'h00);
    chk("post_rst_e2", tx, 0);
    drain();

    phase = "random";
    for (int blk = 0; blk < 6; blk++) begin
      int dens = $urandom_range(1, 10);
      for (int i = 0; i < 300; i++) begin
        step(($urandom_range(0, 9) < dens) ? 1'b1 : 1'b0, 8'($urandom));
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
